// File: rtl/reg_file_sb.sv
// Register file with post-reset zeroing sweep, busy scoreboard and x0 hard-wired to zero.
// Optional same-cycle write-to-read bypass is compiled in with `define REG_FILE_BYPASS_EN.
module reg_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ready,
    input  logic [AW-1:0]   raddr_rs1,
    input  logic [AW-1:0]   raddr_rs2,
    output logic [XLEN-1:0] rdata_rs1,
    output logic [XLEN-1:0] rdata_rs2,
    output logic            busy_rs1,
    output logic            busy_rs2,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_rd,
    input  logic            we,
    input  logic [AW-1:0]   waddr_rd,
    input  logic [XLEN-1:0] wdata_rd
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LP_LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0] LP_ONE  = AW'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_ptr;
    logic [AW-1:0]     w_ptr_nxt;
    logic              r_ready;
    logic              w_ready_nxt;
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_nxt;
    logic [XLEN-1:0]   r_mem [NREGS];

    logic              w_run;
    logic              w_wr_en;
    logic              w_iss_en;
    logic              w_mem_we;
    logic [AW-1:0]     w_mem_addr;
    logic [XLEN-1:0]   w_mem_data;
    logic [XLEN-1:0]   w_rdata_rs1;
    logic [XLEN-1:0]   w_rdata_rs2;
    logic              w_busy_rs1;
    logic              w_busy_rs2;

    assign w_run    = (r_state == ST_RUN);
    assign w_wr_en  = w_run && we && (waddr_rd != '0);
    assign w_iss_en = w_run && issue_we && (issue_rd != '0);

    // Next-state logic: sweep zeros through the array in INIT, then route writeback in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ready_nxt = r_ready;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_ptr;
        w_mem_data  = '0;
        case (r_state)
            ST_INIT: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_ptr;
                w_mem_data = '0;
                w_ptr_nxt  = r_ptr + LP_ONE;
                if (r_ptr == LP_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_INIT;
                    w_ready_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                w_ready_nxt = 1'b1;
                if (w_wr_en) begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = waddr_rd;
                    w_mem_data = wdata_rd;
                end else begin
                    w_mem_we   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_ptr_nxt   = '0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // Scoreboard update: issue sets after writeback clears so the newer producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            w_busy_nxt[i] = (w_iss_en && (issue_rd == AW'(i))) ? 1'b1 :
                            (w_wr_en  && (waddr_rd == AW'(i))) ? 1'b0 : r_busy[i];
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Storage array; never reset directly, the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Read port 1.
    always_comb begin
        w_rdata_rs1 = '0;
        w_busy_rs1  = 1'b0;
        if (w_run && (raddr_rs1 != '0)) begin
            w_rdata_rs1 = r_mem[raddr_rs1];
            w_busy_rs1  = r_busy[raddr_rs1];
`ifdef REG_FILE_BYPASS_EN
            if (w_wr_en && (waddr_rd == raddr_rs1)) begin
                w_rdata_rs1 = wdata_rd;
                w_busy_rs1  = (w_iss_en && (issue_rd == raddr_rs1)) ? r_busy[raddr_rs1] : 1'b0;
            end else begin
            end
`endif
        end else begin
            w_rdata_rs1 = '0;
            w_busy_rs1  = 1'b0;
        end
    end

    // Read port 2.
    always_comb begin
        w_rdata_rs2 = '0;
        w_busy_rs2  = 1'b0;
        if (w_run && (raddr_rs2 != '0)) begin
            w_rdata_rs2 = r_mem[raddr_rs2];
            w_busy_rs2  = r_busy[raddr_rs2];
`ifdef REG_FILE_BYPASS_EN
            if (w_wr_en && (waddr_rd == raddr_rs2)) begin
                w_rdata_rs2 = wdata_rd;
                w_busy_rs2  = (w_iss_en && (issue_rd == raddr_rs2)) ? r_busy[raddr_rs2] : 1'b0;
            end else begin
            end
`endif
        end else begin
            w_rdata_rs2 = '0;
            w_busy_rs2  = 1'b0;
        end
    end

    assign ready     = r_ready;
    assign rdata_rs1 = w_rdata_rs1;
    assign rdata_rs2 = w_rdata_rs2;
    assign busy_rs1  = w_busy_rs1;
    assign busy_rs2  = w_busy_rs2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb: default 32x32 build plus a 64-bit, 16-entry build.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic [4:0]  raddr_rs1, raddr_rs2, issue_rd, waddr_rd;
    logic [31:0] rdata_rs1, rdata_rs2, wdata_rd;
    logic        busy_rs1, busy_rs2, issue_we, we;

    logic        p_ready;
    logic [3:0]  p_raddr_rs1, p_raddr_rs2, p_issue_rd, p_waddr_rd;
    logic [63:0] p_rdata_rs1, p_rdata_rs2, p_wdata_rd;
    logic        p_busy_rs1, p_busy_rs2, p_issue_we, p_we;

    int n_checks;
    int n_pass;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .raddr_rs1(raddr_rs1), .raddr_rs2(raddr_rs2),
        .rdata_rs1(rdata_rs1), .rdata_rs2(rdata_rs2),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .issue_we(issue_we), .issue_rd(issue_rd),
        .we(we), .waddr_rd(waddr_rd), .wdata_rd(wdata_rd)
    );

    reg_file_sb #(.XLEN(64), .NREGS(16)) dut_p (
        .clk(clk), .rst_n(rst_n), .ready(p_ready),
        .raddr_rs1(p_raddr_rs1), .raddr_rs2(p_raddr_rs2),
        .rdata_rs1(p_rdata_rs1), .rdata_rs2(p_rdata_rs2),
        .busy_rs1(p_busy_rs1), .busy_rs2(p_busy_rs2),
        .issue_we(p_issue_we), .issue_rd(p_issue_rd),
        .we(p_we), .waddr_rd(p_waddr_rd), .wdata_rd(p_wdata_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        raddr_rs1 = 5'd0; raddr_rs2 = 5'd0; issue_rd = 5'd0; waddr_rd = 5'd0;
        wdata_rd = 32'h0; issue_we = 1'b0; we = 1'b0;
        p_raddr_rs1 = 4'd0; p_raddr_rs2 = 4'd0; p_issue_rd = 4'd0; p_waddr_rd = 4'd0;
        p_wdata_rd = 64'h0; p_issue_we = 1'b0; p_we = 1'b0;

        // Reset for two edges, then sweep with garbage write/issue traffic held active.
        tick();
        tick();
        chk_value("reset_ready", {63'd0, ready}, 64'd0);
        rst_n = 1'b1;
        we = 1'b1; waddr_rd = 5'd6; wdata_rd = 32'hBAD0BAD0;
        issue_we = 1'b1; issue_rd = 5'd6;
        raddr_rs1 = 5'd6; raddr_rs2 = 5'd31;
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk_value("sweep_ready", {63'd0, ready}, 64'd0);
            chk_value("sweep_rdata", {32'd0, rdata_rs1}, 64'd0);
            chk_value("sweep_busy", {63'd0, busy_rs1}, 64'd0);
            chk_value("p_sweep_ready", {63'd0, p_ready}, (i >= 16) ? 64'd1 : 64'd0);
        end
        tick();
        we = 1'b0; issue_we = 1'b0;
        chk_value("sweep_done_ready", {63'd0, ready}, 64'd1);
        for (int r = 0; r < 32; r++) begin
            raddr_rs1 = 5'(r);
            raddr_rs2 = 5'(31 - r);
            #1;
            chk_value("zero_rs1", {32'd0, rdata_rs1}, 64'd0);
            chk_value("zero_rs2", {32'd0, rdata_rs2}, 64'd0);
            chk_value("zero_busy", {63'd0, busy_rs1}, 64'd0);
        end

        // Wide/short instance: write x15 and read back.
        p_we = 1'b1; p_waddr_rd = 4'd15; p_wdata_rd = 64'hFFFF_0000_FFFF_0000;
        tick();
        p_we = 1'b0; p_raddr_rs1 = 4'd15; p_raddr_rs2 = 4'd3;
        #1;
        chk_value("p_x15", p_rdata_rs1, 64'hFFFF_0000_FFFF_0000);
        chk_value("p_x3", p_rdata_rs2, 64'd0);

        // Write/read, and x0 write dropped.
        we = 1'b1; waddr_rd = 5'd5; wdata_rd = 32'hDEADBEEF;
        tick();
        we = 1'b0; raddr_rs1 = 5'd5;
        #1;
        chk_value("x5_read", {32'd0, rdata_rs1}, 64'hDEADBEEF);
        we = 1'b1; waddr_rd = 5'd0; wdata_rd = 32'h12345678; raddr_rs2 = 5'd0;
        tick();
        we = 1'b0;
        #1;
        chk_value("x0_read", {32'd0, rdata_rs2}, 64'd0);
        chk_value("x5_kept", {32'd0, rdata_rs1}, 64'hDEADBEEF);

        // Scoreboard set and clear.
        issue_we = 1'b1; issue_rd = 5'd7;
        tick();
        issue_we = 1'b0; raddr_rs1 = 5'd7;
        #1;
        chk_value("busy7_set", {63'd0, busy_rs1}, 64'd1);
        we = 1'b1; waddr_rd = 5'd7; wdata_rd = 32'h1;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk_value("busy7_wb_cycle", {63'd0, busy_rs1}, 64'd0);
`else
        chk_value("busy7_wb_cycle", {63'd0, busy_rs1}, 64'd1);
`endif
        tick();
        we = 1'b0;
        #1;
        chk_value("busy7_clear", {63'd0, busy_rs1}, 64'd0);
        chk_value("x7_read", {32'd0, rdata_rs1}, 64'd1);

        // Same-register issue and writeback: set wins.
        issue_we = 1'b1; issue_rd = 5'd9; we = 1'b1; waddr_rd = 5'd9; wdata_rd = 32'h99;
        tick();
        issue_we = 1'b0; we = 1'b0; raddr_rs1 = 5'd9;
        #1;
        chk_value("busy9_setwins", {63'd0, busy_rs1}, 64'd1);
        chk_value("x9_read", {32'd0, rdata_rs1}, 64'h99);

        // Different registers same cycle: both apply.
        issue_we = 1'b1; issue_rd = 5'd11; we = 1'b1; waddr_rd = 5'd9; wdata_rd = 32'h55;
        tick();
        issue_we = 1'b0; we = 1'b0; raddr_rs1 = 5'd9; raddr_rs2 = 5'd11;
        #1;
        chk_value("busy9_cleared", {63'd0, busy_rs1}, 64'd0);
        chk_value("busy11_set", {63'd0, busy_rs2}, 64'd1);

        // Bypass window: x10 busy, writeback x10 while reading it.
        issue_we = 1'b1; issue_rd = 5'd10;
        tick();
        issue_we = 1'b0;
        we = 1'b1; waddr_rd = 5'd10; wdata_rd = 32'hCAFE0001; raddr_rs1 = 5'd10;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk_value("byp_rdata", {32'd0, rdata_rs1}, 64'hCAFE0001);
        chk_value("byp_busy", {63'd0, busy_rs1}, 64'd0);
`else
        chk_value("byp_rdata", {32'd0, rdata_rs1}, 64'd0);
        chk_value("byp_busy", {63'd0, busy_rs1}, 64'd1);
`endif
        tick();
        we = 1'b0;
        #1;
        chk_value("x10_after", {32'd0, rdata_rs1}, 64'hCAFE0001);
        chk_value("busy10_after", {63'd0, busy_rs1}, 64'd0);

        // Bypass with a same-register reissue keeps the stored busy bit.
        issue_we = 1'b1; issue_rd = 5'd12;
        tick();
        we = 1'b1; waddr_rd = 5'd12; wdata_rd = 32'h0000_1212; raddr_rs2 = 5'd12;
        #1;
        chk_value("reissue_busy_cycle", {63'd0, busy_rs2}, 64'd1);
`ifdef REG_FILE_BYPASS_EN
        chk_value("reissue_rdata_cycle", {32'd0, rdata_rs2}, 64'h1212);
`else
        chk_value("reissue_rdata_cycle", {32'd0, rdata_rs2}, 64'd0);
`endif
        tick();
        we = 1'b0; issue_we = 1'b0;
        #1;
        chk_value("reissue_busy_after", {63'd0, busy_rs2}, 64'd1);

        // Mid-run reset clears ready and scoreboard, sweep re-zeros data.
        we = 1'b1; waddr_rd = 5'd3; wdata_rd = 32'hA5A5A5A5; issue_we = 1'b1; issue_rd = 5'd4;
        tick();
        we = 1'b0; issue_we = 1'b0; raddr_rs1 = 5'd3; raddr_rs2 = 5'd4;
        #1;
        chk_value("x3_pre_reset", {32'd0, rdata_rs1}, 64'hA5A5A5A5);
        chk_value("busy4_pre_reset", {63'd0, busy_rs2}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        raddr_rs1 = 5'd4;
        #1;
        chk_value("rst_ready", {63'd0, ready}, 64'd0);
        chk_value("rst_busy4", {63'd0, busy_rs1}, 64'd0);
        for (int i = 1; i <= 31; i++) begin
            tick();
        end
        chk_value("resweep_ready_31", {63'd0, ready}, 64'd0);
        tick();
        chk_value("resweep_ready_32", {63'd0, ready}, 64'd1);
        raddr_rs1 = 5'd3; raddr_rs2 = 5'd4;
        #1;
        chk_value("x3_zeroed", {32'd0, rdata_rs1}, 64'd0);
        chk_value("busy4_run", {63'd0, busy_rs2}, 64'd0);
        p_raddr_rs1 = 4'd15;
        #1;
        chk_value("p_x15_zeroed", p_rdata_rs1, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
